// File: rtl/regfile_write_ctrl_pkg.sv
// regfile_ctrl_pkg: shared states, ALU codes, opcode/funct encodings and register range limits
package regfile_ctrl_pkg;
   typedef enum logic [2:0] {IDLE, DECODE, EXECUTE, SETTLE, WRITEBACK} state_t;
   localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3, ALU_SLT = 3'd4;
   localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D;
   localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;
   localparam logic [4:0] REG_MIN = 5'd8, REG_MAX = 5'd23;
   function automatic logic in_range(input logic [4:0] r);
      return r >= REG_MIN && r <= REG_MAX;
   endfunction
endpackage

// File: rtl/regfile_write_ctrl_if.sv
// regfile_write_ctrl_if: instruction handshake, ALU and register-file signals of the write controller
interface regfile_write_ctrl_if #(parameter int REG_IDX_W = 6);
   logic [31:0] instr;
   logic instr_valid, instr_ready;
   logic [31:0] alu_result;
   logic [REG_IDX_W-1:0] reg1, reg2, reg3;
   logic reg_dest, reg_write;
   logic [31:0] wdat;
   logic [2:0] alu_op;
   logic alu_src;
   logic [31:0] imm_ext;
   logic done, err;
   modport master (output instr, instr_valid, alu_result,
                   input instr_ready, reg1, reg2, reg3, reg_dest, reg_write, wdat, alu_op, alu_src, imm_ext, done, err);
   modport slave (input instr, instr_valid, alu_result,
                  output instr_ready, reg1, reg2, reg3, reg_dest, reg_write, wdat, alu_op, alu_src, imm_ext, done, err);
endinterface

// File: rtl/regfile_write_ctrl_instr_decoder.sv
// instr_decoder: combinational MIPS decode of ALU controls and legality; REG_RANGE_CHECK_EN limits indices to 8..23
module instr_decoder
   import regfile_ctrl_pkg::*;
(
   input logic [31:0] instr,
   output logic [2:0] alu_op,
   output logic alu_src,
   output logic reg_dest,
   output logic [31:0] imm_ext,
   output logic illegal
);
   logic [5:0] op, fn;
   logic rtype, enc_ok, range_ok;
   assign op = instr[31:26];
   assign fn = instr[5:0];
   assign rtype = op == OP_RTYPE;
   assign enc_ok = rtype ? fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT} : op inside {OP_ADDI, OP_ANDI, OP_ORI};
   assign alu_op = rtype ? (fn == FN_SUB ? ALU_SUB : fn == FN_AND ? ALU_AND : fn == FN_OR ? ALU_OR : fn == FN_SLT ? ALU_SLT : ALU_ADD)
                         : (op == OP_ANDI ? ALU_AND : op == OP_ORI ? ALU_OR : ALU_ADD);
   assign alu_src = !rtype;
   assign reg_dest = rtype;
   assign imm_ext = op == OP_ADDI ? {{16{instr[15]}}, instr[15:0]} : {16'h0, instr[15:0]};
`ifdef REG_RANGE_CHECK_EN
   assign range_ok = in_range(instr[25:21]) && in_range(instr[20:16]) && (!rtype || in_range(instr[15:11]));
`else
   logic unused_idx;
   assign unused_idx = ^instr[25:16];
   assign range_ok = 1'b1;
`endif
   assign illegal = !(enc_ok && range_ok);
endmodule

// File: rtl/regfile_write_ctrl.sv
// regfile_write_ctrl: multicycle decode/execute/settle/writeback sequencer feeding the register file (REG_RANGE_CHECK_EN optional)
module regfile_write_ctrl
   import regfile_ctrl_pkg::*;
#(
   parameter int ALU_LAT = 1,
   parameter int REG_IDX_W = 6
) (
   input logic clk,
   input logic rst_n,
   regfile_write_ctrl_if.slave bus
);
   localparam logic [1:0] LAST = 2'(ALU_LAT - 1);
   state_t state;
   logic [1:0] cnt;
   logic [2:0] dec_alu_op;
   logic dec_alu_src, dec_reg_dest, dec_illegal;
   logic [31:0] dec_imm_ext;
   instr_decoder u_dec (
      .instr(bus.instr),
      .alu_op(dec_alu_op),
      .alu_src(dec_alu_src),
      .reg_dest(dec_reg_dest),
      .imm_ext(dec_imm_ext),
      .illegal(dec_illegal)
   );
   // Sequencer: decoded controls are registered at the accept edge so they are visible throughout DECODE
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         bus.instr_ready <= 1'b1;
         bus.reg1 <= '0;
         bus.reg2 <= '0;
         bus.reg3 <= '0;
         bus.reg_dest <= 1'b0;
         bus.reg_write <= 1'b0;
         bus.wdat <= '0;
         bus.alu_op <= '0;
         bus.alu_src <= 1'b0;
         bus.imm_ext <= '0;
         bus.done <= 1'b0;
         bus.err <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.instr_valid) begin
               bus.instr_ready <= 1'b0;
               bus.reg1 <= REG_IDX_W'(bus.instr[25:21]);
               bus.reg2 <= REG_IDX_W'(bus.instr[20:16]);
               bus.reg3 <= REG_IDX_W'(bus.instr[15:11]);
               bus.reg_dest <= dec_reg_dest;
               bus.alu_op <= dec_alu_op;
               bus.alu_src <= dec_alu_src;
               bus.imm_ext <= dec_imm_ext;
               bus.err <= dec_illegal;
               state <= DECODE;
            end
            DECODE: begin
               bus.err <= 1'b0;
               bus.instr_ready <= bus.err;
               state <= bus.err ? IDLE : EXECUTE;
            end
            EXECUTE: if (cnt == LAST) begin
               bus.wdat <= bus.alu_result;
               cnt <= '0;
               state <= SETTLE;
            end else cnt <= cnt + 2'd1;
            SETTLE: begin
               bus.reg_write <= |(bus.reg_dest ? bus.reg3 : bus.reg2);
               bus.done <= 1'b1;
               state <= WRITEBACK;
            end
            WRITEBACK: begin
               bus.reg_write <= 1'b0;
               bus.done <= 1'b0;
               bus.instr_ready <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
